ws2812_chain_driver: RTL and testbench

- Parametrised serial driver for a chain of WS2812-style addressable LEDs.
- Generalises the fixed six-LED driver:
  - LED count and bit timing are parameters.
  - start/ready handshake replaces the level load.
  - Reset latch period is guaranteed before done.
- Sits between the colour/pattern logic and the single LED data pin on the FPGA.

---
 rtl/ws2812_chain_driver.sv | 166 ++++++++++++++++
 tb/tb_ws2812_chain_driver.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_chain_driver.sv
// Serial driver for a chain of WS2812-style LEDs. It takes a start/ready handshake, sends the frame MSB-first, then holds a latch period before done.
// Optional build macro WS2812_BRIGHTNESS_EN adds a brightness input that scales every colour byte when start is accepted.
module ws2812_chain_driver #(
  parameter int unsigned NUM_LEDS  = 6,
  parameter int unsigned T0H       = 19,
  parameter int unsigned T1H       = 38,
  parameter int unsigned TBIT      = 60,
  parameter int unsigned RESET_CYC = 14400
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [NUM_LEDS*24-1:0]   frame,
`ifdef WS2812_BRIGHTNESS_EN
  input  logic [7:0]               brightness,
`endif
  output logic                     ready,
  output logic                     busy,
  output logic                     done,
  output logic                     data_out
);

  localparam int unsigned FW     = NUM_LEDS * 24;
  localparam int unsigned LO_MAX = TBIT - T0H;
  localparam int unsigned CMAX_A = (T1H > LO_MAX) ? T1H : LO_MAX;
  localparam int unsigned CMAX   = (CMAX_A > RESET_CYC) ? CMAX_A : RESET_CYC;
  localparam int unsigned CW     = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int unsigned BW     = $clog2(24);
  localparam int unsigned LW     = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIGH,
    S_LOW,
    S_LATCH
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [LW-1:0]   led_q, led_d;
  logic [FW-1:0]   shift_q, shift_d;
  logic [FW-1:0]   frame_load;
  logic            ready_d, busy_d, done_d, data_d;
  logic [CW-1:0]   hi_len, lo_len;
  logic            last_bit;

`ifdef WS2812_BRIGHTNESS_EN
  logic [15:0] prod;

  // Each byte is scaled by (brightness+1)/256, so 255 passes data through unchanged and 0 blanks it.
  always_comb begin
    frame_load = '0;
    prod       = '0;
    for (int i = 0; i < int'(FW / 8); i++) begin
      prod                  = 16'(frame[i*8 +: 8]) * (16'(brightness) + 16'd1);
      frame_load[i*8 +: 8]  = prod[15:8];
    end
  end
`else
  assign frame_load = frame;
`endif

  // The high and low phase lengths depend on the bit that is being sent now.
  assign hi_len   = shift_q[FW-1] ? CW'(T1H) : CW'(T0H);
  assign lo_len   = shift_q[FW-1] ? CW'(TBIT - T1H) : CW'(TBIT - T0H);
  assign last_bit = (bit_q == BW'(23)) && (led_q == LW'(NUM_LEDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      led_q    <= '0;
      shift_q  <= '0;
      ready    <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      data_out <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      led_q    <= led_d;
      shift_q  <= shift_d;
      ready    <= ready_d;
      busy     <= busy_d;
      done     <= done_d;
      data_out <= data_d;
    end
  end

  // Next-state logic. The outputs are computed one cycle early so that they are registered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    led_d   = led_q;
    shift_d = shift_q;
    ready_d = ready;
    busy_d  = busy;
    done_d  = 1'b0;
    data_d  = data_out;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_HIGH;
          cnt_d   = '0;
          bit_d   = '0;
          led_d   = '0;
          shift_d = frame_load;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          data_d  = 1'b1;
        end
      end

      S_HIGH: begin
        if (cnt_q == hi_len - CW'(1)) begin
          state_d = S_LOW;
          cnt_d   = '0;
          data_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_LOW: begin
        if (cnt_q == lo_len - CW'(1)) begin
          cnt_d   = '0;
          shift_d = {shift_q[FW-2:0], 1'b0};
          if (last_bit) begin
            state_d = S_LATCH;
          end else begin
            state_d = S_HIGH;
            data_d  = 1'b1;
            if (bit_q == BW'(23)) begin
              bit_d = '0;
              led_d = led_q + LW'(1);
            end else begin
              bit_d = bit_q + BW'(1);
            end
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_LATCH: begin
        if (cnt_q == CW'(RESET_CYC - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ws2812_chain_driver.sv
// Bench for ws2812_chain_driver. It sends directed and random frames and checks the captured waveform against a bit-timing model.
module tb_ws2812_chain_driver;

  localparam int unsigned NUM_LEDS  = 2;
  localparam int unsigned T0H       = 2;
  localparam int unsigned T1H       = 4;
  localparam int unsigned TBIT      = 6;
  localparam int unsigned RESET_CYC = 10;
  localparam int unsigned FW        = NUM_LEDS * 24;
  localparam int          FRAME_CYC = int'(FW * TBIT + RESET_CYC);
  localparam int          MAXC      = FRAME_CYC + 20;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [FW-1:0] frame;
  logic [7:0]    brightness;
  logic          ready, busy, done, data_out;

  int n_cmp;
  int n_bad;

  logic cap_data  [MAXC];
  logic cap_busy  [MAXC];
  logic cap_ready [MAXC];
  logic cap_done  [MAXC];
  int   cap_len;
  int   cap_done_at;

  ws2812_chain_driver #(
    .NUM_LEDS  (NUM_LEDS),
    .T0H       (T0H),
    .T1H       (T1H),
    .TBIT      (TBIT),
    .RESET_CYC (RESET_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .frame      (frame),
`ifdef WS2812_BRIGHTNESS_EN
    .brightness (brightness),
`endif
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .data_out   (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [FW-1:0] rnd_frame();
    return FW'({$urandom(), $urandom()});
  endfunction

  // Returns the bytes the chain should actually receive.
  function automatic logic [FW-1:0] model_frame(input logic [FW-1:0] f, input logic [7:0] br);
    logic [FW-1:0] m;
    m = f;
`ifdef WS2812_BRIGHTNESS_EN
    for (int i = 0; i < int'(FW / 8); i++) begin
      int c;
      c = int'(f[i*8 +: 8]);
      m[i*8 +: 8] = 8'((c * (int'(br) + 1)) / 256);
    end
`endif
    return m;
  endfunction

  // Expected line level j cycles after the accepting edge.
  function automatic logic exp_level(input logic [FW-1:0] mf, input int j);
    int b, pos, hi;
    if (j >= int'(FW * TBIT)) return 1'b0;
    b   = j / int'(TBIT);
    pos = j % int'(TBIT);
    hi  = mf[FW-1-b] ? int'(T1H) : int'(T0H);
    return pos < hi;
  endfunction

  // Counts the captured cycles that do not match the model in level or handshake state.
  function automatic int trace_errors(input logic [FW-1:0] mf);
    int e;
    e = 0;
    for (int j = 0; j < cap_len; j++) begin
      if (cap_data[j]  !== exp_level(mf, j))  e++;
      if (cap_busy[j]  !== (j < FRAME_CYC))   e++;
      if (cap_ready[j] !== (j >= FRAME_CYC))  e++;
      if (cap_done[j]  !== (j == FRAME_CYC))  e++;
    end
    return e;
  endfunction

  // Waits for the accepting edge, then records the outputs each cycle until done or until the cycle budget runs out.
  task automatic capture(input int inject_at, input logic [FW-1:0] inj_frame,
                         input bit hold, input logic [FW-1:0] next_frame);
    cap_len     = 0;
    cap_done_at = -1;
    @(posedge clk);
    for (int j = 0; j < MAXC; j++) begin
      @(negedge clk);
      cap_data[j]  = data_out;
      cap_busy[j]  = busy;
      cap_ready[j] = ready;
      cap_done[j]  = done;
      cap_len      = j + 1;
      start        = hold || (j + 1 == inject_at);
      frame        = (j + 1 == inject_at) ? inj_frame : next_frame;
      brightness   = 8'($urandom());
      if (done === 1'b1) begin
        cap_done_at = j;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    start = 1'b0;
    frame = '0;
    brightness = 8'hFF;
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({data_out, ready, busy, done} !== 4'b0100) begin
      n_bad++;
      $display("FAIL reset_async: got %b want 0100", {data_out, ready, busy, done});
    end
    #1 rst_n = 1'b1;
    #1;
    n_cmp++;
    if ({data_out, ready, busy, done} !== 4'b0100) begin
      n_bad++;
      $display("FAIL reset_release: got %b want 0100", {data_out, ready, busy, done});
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({data_out, ready, busy, done} !== 4'b0100) begin
      n_bad++;
      $display("FAIL reset_idle_clocked: got %b want 0100", {data_out, ready, busy, done});
    end
  endtask

  task automatic test_frame();
    logic [FW-1:0] f;
    int e;
    f = 48'hFF0000_00FF01;
    @(negedge clk);
    n_cmp++;
    if (ready !== 1'b1) begin
      n_bad++;
      $display("FAIL frame_ready_before: got %b want 1", ready);
    end
    brightness = 8'hFF;
    frame = f;
    start = 1'b1;
    capture(-1, '0, 1'b0, rnd_frame());
    n_cmp++;
    if (cap_done_at !== FRAME_CYC) begin
      n_bad++;
      $display("FAIL frame_done_cycle: got %0d want %0d", cap_done_at, FRAME_CYC);
    end
    e = trace_errors(model_frame(f, 8'hFF));
    n_cmp++;
    if (e !== 0) begin
      n_bad++;
      $display("FAIL frame_waveform: got %0d bad cycles want 0", e);
    end
  endtask

  task automatic test_start_while_busy();
    logic [FW-1:0] f;
    int e;
    f = rnd_frame();
    @(negedge clk);
    brightness = 8'hFF;
    frame = f;
    start = 1'b1;
    capture(50, ~f, 1'b0, rnd_frame());
    e = trace_errors(model_frame(f, 8'hFF));
    n_cmp++;
    if (e !== 0 || cap_done_at !== FRAME_CYC) begin
      n_bad++;
      $display("FAIL busy_start_ignored: got %0d bad cycles done at %0d want 0 / %0d",
               e, cap_done_at, FRAME_CYC);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({ready, busy, done, data_out} !== 4'b1000) begin
      n_bad++;
      $display("FAIL busy_start_not_queued: got %b want 1000", {ready, busy, done, data_out});
    end
  endtask

  task automatic test_back_to_back();
    logic [FW-1:0] fa, fb;
    int ea, eb;
    fa = rnd_frame();
    fb = rnd_frame();
    @(negedge clk);
    brightness = 8'hFF;
    frame = fa;
    start = 1'b1;
    capture(-1, '0, 1'b1, fb);
    ea = trace_errors(model_frame(fa, 8'hFF));
    n_cmp++;
    if (ea !== 0 || cap_done_at !== FRAME_CYC) begin
      n_bad++;
      $display("FAIL b2b_first: got %0d bad cycles done at %0d want 0 / %0d",
               ea, cap_done_at, FRAME_CYC);
    end
    brightness = 8'hFF;
    capture(-1, '0, 1'b0, rnd_frame());
    n_cmp++;
    if (cap_data[0] !== 1'b1 || cap_busy[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_no_gap: got data %b busy %b want 1 1", cap_data[0], cap_busy[0]);
    end
    eb = trace_errors(model_frame(fb, 8'hFF));
    n_cmp++;
    if (eb !== 0 || cap_done_at !== FRAME_CYC) begin
      n_bad++;
      $display("FAIL b2b_second: got %0d bad cycles done at %0d want 0 / %0d",
               eb, cap_done_at, FRAME_CYC);
    end
  endtask

  task automatic test_mid_reset();
    logic [FW-1:0] f, mf;
    int j, e;
    f  = 48'hFF0000_00FF01;
    mf = model_frame(f, 8'hFF);
    @(negedge clk);
    brightness = 8'hFF;
    frame = f;
    start = 1'b1;
    @(posedge clk);
    j = 0;
    while (j < MAXC) begin
      @(negedge clk);
      start = 1'b0;
      if (j >= 100 && exp_level(mf, j)) break;
      j++;
    end
    n_cmp++;
    if (data_out !== exp_level(mf, j)) begin
      n_bad++;
      $display("FAIL mid_reset_pre_level: got %b want %b at cycle %0d", data_out, exp_level(mf, j), j);
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({data_out, ready, busy, done} !== 4'b0100) begin
      n_bad++;
      $display("FAIL mid_reset_async: got %b want 0100", {data_out, ready, busy, done});
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    f = rnd_frame();
    frame = f;
    brightness = 8'hFF;
    start = 1'b1;
    capture(-1, '0, 1'b0, rnd_frame());
    e = trace_errors(model_frame(f, 8'hFF));
    n_cmp++;
    if (e !== 0 || cap_done_at !== FRAME_CYC) begin
      n_bad++;
      $display("FAIL mid_reset_restart: got %0d bad cycles done at %0d want 0 / %0d",
               e, cap_done_at, FRAME_CYC);
    end
  endtask

  task automatic test_random();
    logic [FW-1:0] f;
    logic [7:0] br;
    int e;
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      @(negedge clk);
      f  = rnd_frame();
      br = 8'($urandom());
      frame = f;
      brightness = br;
      start = 1'b1;
      capture(int'($urandom_range(1, FRAME_CYC - 1)), rnd_frame(), 1'b0, rnd_frame());
      e = trace_errors(model_frame(f, br));
      n_cmp++;
      if (e !== 0 || cap_done_at !== FRAME_CYC) begin
        n_bad++;
        $display("FAIL random_frame_%0d: got %0d bad cycles done at %0d want 0 / %0d",
                 k, e, cap_done_at, FRAME_CYC);
      end
    end
  endtask

`ifdef WS2812_BRIGHTNESS_EN
  task automatic test_brightness();
    logic [FW-1:0] f;
    int e;
    f = 48'hFF8001_000000;
    @(negedge clk);
    frame = f;
    brightness = 8'h7F;
    start = 1'b1;
    capture(-1, '0, 1'b0, rnd_frame());
    e = trace_errors(48'h7F4000_000000);
    n_cmp++;
    if (e !== 0 || cap_done_at !== FRAME_CYC) begin
      n_bad++;
      $display("FAIL brightness_scale: got %0d bad cycles done at %0d want 0 / %0d",
               e, cap_done_at, FRAME_CYC);
    end
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_frame();
    test_start_while_busy();
    test_back_to_back();
    test_mid_reset();
`ifdef WS2812_BRIGHTNESS_EN
    test_brightness();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
